miner_host_ctrl: RTL and testbench

MINER_HOST_CTRL -- requirements
Module: miner_host_ctrl

---
 rtl/miner_host_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_miner_host_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/miner_host_ctrl.sv
// Host-side controller for the miner core: loads midstate/work, then steps the
// nonce each time the core reports a miss, until a hit, exhaustion or an exception.
package miner_host_pkg;
    localparam int unsigned mask_length_gp = 3;

    typedef enum logic [1:0] {
        OP_NULL = 2'd0,
        OP_REG  = 2'd1,
        OP_PC   = 2'd2,
        OP_BAR  = 2'd3
    } net_op_e;

    typedef struct packed {
        logic [9:0]  id;
        logic [1:0]  reserved;
        net_op_e     op;
        logic [9:0]  addr;
        logic [31:0] data;
    } net_packet_s;
endpackage

module miner_host_ctrl
    import miner_host_pkg::*;
#(
    parameter logic [9:0]  ID_P     = 10'd1,
    parameter int unsigned BLANK_P  = 2,
    parameter int unsigned SETTLE_P = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    input  logic [255:0]                    midstate_i,
    input  logic [95:0]                     work_i,
    input  logic [31:0]                     nonce_start_i,
    input  logic [mask_length_gp-1:0]       barrier_i,
    input  logic                            exception_i,
    output logic [$bits(net_packet_s)-1:0]  net_packet_flat_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            found_o,
    output logic                            exhausted_o,
    output logic                            error_o,
    output logic [31:0]                     nonce_o
);

    localparam logic [9:0]  ADDR_CTRL  = 10'd24;
    localparam logic [9:0]  ADDR_CMD   = 10'd20;
    localparam logic [31:0] NULL_DATA  = 32'hFFFF_FFFE;
    localparam logic [1:0]  CMD_LDWORK  = 2'd1;
    localparam logic [1:0]  CMD_LDNONCE = 2'd2;
    localparam logic [1:0]  CMD_FINISH  = 2'd3;

    typedef enum logic [3:0] {
        IDLE, BAR, LDREG, CMD, PC, WAIT, SETTLE, NONCE, DONE
    } state_e;

    function automatic net_packet_s mk_pkt(net_op_e op, logic [9:0] addr, logic [31:0] data);
        net_packet_s p;
        p      = '0;
        p.id   = ID_P;
        p.op   = op;
        p.addr = addr;
        p.data = data;
        return p;
    endfunction

    state_e       r_state;
    net_packet_s  r_pkt;
    logic [351:0] r_ld;
    logic [3:0]   r_idx;
    logic [31:0]  r_nstart;
    logic [31:0]  r_nonce;
    logic [1:0]   r_cmd;
    logic [7:0]   r_blank;
    logic [7:0]   r_settle;
    logic         r_busy, r_done, r_found, r_exh, r_err;

    assign net_packet_flat_o = r_pkt;
    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign found_o           = r_found;
    assign exhausted_o       = r_exh;
    assign error_o           = r_err;
    assign nonce_o           = r_nonce;

    // r_state always names the packet currently held in r_pkt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pkt    <= mk_pkt(OP_NULL, ADDR_CTRL, NULL_DATA);
            r_ld     <= '0;
            r_idx    <= '0;
            r_nstart <= '0;
            r_nonce  <= '0;
            r_cmd    <= '0;
            r_blank  <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_exh    <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == IDLE || r_state == DONE) begin
            if (start_i) begin
                r_state  <= BAR;
                r_pkt    <= mk_pkt(OP_BAR, ADDR_CTRL, 32'd7);
                r_ld     <= {midstate_i, work_i};
                r_nstart <= nonce_start_i;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
                r_found  <= 1'b0;
                r_exh    <= 1'b0;
                r_err    <= 1'b0;
            end
        end else if (exception_i) begin
            r_state <= DONE;
            r_pkt   <= mk_pkt(OP_NULL, ADDR_CTRL, NULL_DATA);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
        end else begin
            case (r_state)
                BAR: begin
                    r_state <= LDREG;
                    r_pkt   <= mk_pkt(OP_REG, 10'd1, r_ld[351 -: 32]);
                    r_ld    <= r_ld << 32;
                    r_idx   <= 4'd1;
                end
                LDREG: begin
                    if (r_idx == 4'd11) begin
                        r_state <= CMD;
                        r_pkt   <= mk_pkt(OP_REG, ADDR_CMD, {30'd0, CMD_LDWORK});
                        r_cmd   <= CMD_LDWORK;
                    end else begin
                        r_pkt <= mk_pkt(OP_REG, {6'd0, r_idx} + 10'd1, r_ld[351 -: 32]);
                        r_ld  <= r_ld << 32;
                        r_idx <= r_idx + 4'd1;
                    end
                end
                NONCE: begin
                    r_state <= CMD;
                    r_pkt   <= mk_pkt(OP_REG, ADDR_CMD, {30'd0, CMD_LDNONCE});
                    r_cmd   <= CMD_LDNONCE;
                end
                CMD: begin
                    r_state <= PC;
                    r_pkt   <= mk_pkt(OP_PC, 10'd0, 32'd2);
                    r_blank <= 8'(BLANK_P);
                end
                PC: begin
                    r_pkt <= mk_pkt(OP_NULL, ADDR_CTRL, NULL_DATA);
                    if (r_cmd == CMD_FINISH) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_found <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Blanking hides the core's stale result from before the PC packet.
                    if (r_blank != '0) begin
                        r_blank <= r_blank - 8'd1;
                    end else if (barrier_i == 3'b000) begin
                        if (r_cmd == CMD_LDWORK) begin
                            r_nonce  <= r_nstart;
                            r_state  <= SETTLE;
                            r_settle <= 8'(SETTLE_P);
                        end else if (r_nonce == 32'hFFFF_FFFF) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_exh   <= 1'b1;
                        end else begin
                            r_nonce  <= r_nonce + 32'd1;
                            r_state  <= SETTLE;
                            r_settle <= 8'(SETTLE_P);
                        end
                    end else if (barrier_i == 3'b001) begin
                        r_cmd    <= CMD_FINISH;
                        r_state  <= SETTLE;
                        r_settle <= 8'(SETTLE_P);
                    end
                end
                SETTLE: begin
                    if (r_settle > 8'd1) begin
                        r_settle <= r_settle - 8'd1;
                    end else if (r_cmd == CMD_FINISH) begin
                        r_state <= CMD;
                        r_pkt   <= mk_pkt(OP_REG, ADDR_CMD, {30'd0, CMD_FINISH});
                    end else begin
                        r_state <= NONCE;
                        r_pkt   <= mk_pkt(OP_REG, 10'd1, r_nonce);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pkt   <= mk_pkt(OP_NULL, ADDR_CTRL, NULL_DATA);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miner_host_ctrl.sv
// Directed bench for miner_host_ctrl: load, iterate, found, exhaust, blanking,
// exception abort, mid-run reset and restart.
module tb_miner_host_ctrl;
    import miner_host_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [255:0] midstate_i;
    logic [95:0]  work_i;
    logic [31:0]  nonce_start_i;
    logic [2:0]   barrier_i;
    logic         exception_i;
    logic [55:0]  pkt;
    logic         busy_o, done_o, found_o, exhausted_o, error_o;
    logic [31:0]  nonce_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    miner_host_ctrl #(.ID_P(10'd1), .BLANK_P(2), .SETTLE_P(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .midstate_i        (midstate_i),
        .work_i            (work_i),
        .nonce_start_i     (nonce_start_i),
        .barrier_i         (barrier_i),
        .exception_i       (exception_i),
        .net_packet_flat_o (pkt),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .found_o           (found_o),
        .exhausted_o       (exhausted_o),
        .error_o           (error_o),
        .nonce_o           (nonce_o)
    );

    always #5 clk = ~clk;

    // Packet layout: id[55:46] reserved[45:44] op[43:42] addr[41:32] data[31:0]
    function automatic logic [55:0] ep(logic [1:0] op, logic [9:0] a, logic [31:0] d);
        return {10'd1, 2'b00, op, a, d};
    endfunction

    localparam logic [55:0] NULLP = {10'd1, 2'b00, 2'd0, 10'd24, 32'hFFFF_FFFE};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_done(input string tag, input logic f, input logic x, input logic e,
                            input logic [31:0] n);
        chk({tag, "_pkt"},   pkt, NULLP);
        chk({tag, "_done"},  done_o, 1'b1);
        chk({tag, "_busy"},  busy_o, 1'b0);
        chk({tag, "_found"}, found_o, f);
        chk({tag, "_exh"},   exhausted_o, x);
        chk({tag, "_err"},   error_o, e);
        chk({tag, "_nonce"}, nonce_o, n);
    endtask

    // Starts a run and checks BAR, 11 REGs, CMD(1) and PC; returns in the PC cycle.
    task automatic do_load(input logic [31:0] ns);
        logic [31:0] w;
        nonce_start_i = ns;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("bar", pkt, ep(OP_BAR, 10'd24, 32'd7));
        chk("busy_load", busy_o, 1'b1);
        chk("done_clr", done_o, 1'b0);
        for (int k = 0; k < 11; k++) begin
            tick();
            if (k < 8) w = midstate_i[255 - 32*k -: 32];
            else       w = work_i[95 - 32*(k-8) -: 32];
            chk("ldreg", pkt, ep(OP_REG, 10'(k + 1), w));
        end
        tick();
        chk("cmd_ldwork", pkt, ep(OP_REG, 10'd20, 32'd1));
        tick();
        chk("pc_load", pkt, ep(OP_PC, 10'd0, 32'd2));
    endtask

    // Lets blanking expire in WAIT, then presents one barrier result for one cycle.
    task automatic pulse(input logic [2:0] b);
        barrier_i = 3'b010;
        repeat (3) tick();
        barrier_i = b;
        tick();
        barrier_i = 3'b010;
    endtask

    // Bounded wait through SETTLE; counts NULLs before the next non-NULL packet.
    task automatic count_settle();
        int unsigned nulls = 1;
        chk("settle_first_null", pkt, NULLP);
        tick();
        while (pkt[43:42] == 2'd0 && nulls < 20) begin
            nulls++;
            tick();
        end
        chk("settle_nulls", nulls, 2);
    endtask

    task automatic expect_iter(input logic [31:0] n);
        count_settle();
        chk("nonce_reg", pkt, ep(OP_REG, 10'd1, n));
        chk("nonce_o", nonce_o, n);
        tick();
        chk("cmd_ldnonce", pkt, ep(OP_REG, 10'd20, 32'd2));
        tick();
        chk("pc_nonce", pkt, ep(OP_PC, 10'd0, 32'd2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        start_i       = 1'b0;
        exception_i   = 1'b0;
        barrier_i     = 3'b010;
        midstate_i    = 256'h56f6950a_9e3ab5c1_0d4f7a22_71be0c93_3a5d8e14_e2c74f06_8b19d3a7_c01823e1;
        work_i        = 96'ha24c2683_cf1beb52_2cf50119;
        nonce_start_i = 32'd5;
        repeat (2) tick();
        chk("rst_pkt",   pkt, NULLP);
        chk("rst_busy",  busy_o, 1'b0);
        chk("rst_done",  done_o, 1'b0);
        chk("rst_found", found_o, 1'b0);
        chk("rst_exh",   exhausted_o, 1'b0);
        chk("rst_err",   error_o, 1'b0);
        chk("rst_nonce", nonce_o, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_pkt", pkt, NULLP);
        chk("idle_busy", busy_o, 1'b0);

        // Load, then blanking: stale 000 during PC and the next cycle, then 010
        do_load(32'd5);
        barrier_i = 3'b000;
        tick();
        chk("wait_null", pkt, NULLP);
        tick();
        barrier_i = 3'b010;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("blank_stay_pkt", pkt, NULLP);
            chk("blank_stay_busy", busy_o, 1'b1);
        end

        // Iterate 5, 6, 7 then found
        pulse(3'b000);
        expect_iter(32'd5);
        pulse(3'b000);
        expect_iter(32'd6);
        pulse(3'b000);
        expect_iter(32'd7);
        pulse(3'b001);
        count_settle();
        chk("cmd_finish", pkt, ep(OP_REG, 10'd20, 32'd3));
        tick();
        chk("pc_finish", pkt, ep(OP_PC, 10'd0, 32'd2));
        tick();
        chk_done("found", 1'b1, 1'b0, 1'b0, 32'd7);

        // Exhaust from FFFFFFFE
        do_load(32'hFFFF_FFFE);
        pulse(3'b000);
        expect_iter(32'hFFFF_FFFE);
        pulse(3'b000);
        expect_iter(32'hFFFF_FFFF);
        pulse(3'b000);
        chk_done("exh", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_third_nonce", pkt, NULLP);
        end

        // Exception in LDREG; start while busy is ignored
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("abort_bar", pkt, ep(OP_BAR, 10'd24, 32'd7));
        tick();
        chk("abort_reg1", pkt, ep(OP_REG, 10'd1, 32'h56f6950a));
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_ignored", pkt, ep(OP_REG, 10'd2, 32'h9e3ab5c1));
        exception_i = 1'b1;
        tick();
        exception_i = 1'b0;
        chk_done("abort", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        tick();
        chk("abort_stay_null", pkt, NULLP);

        // Asynchronous reset mid-WAIT, then restart
        do_load(32'd5);
        repeat (2) tick();
        reset = 1'b1;
        #2;
        chk("arst_pkt",   pkt, NULLP);
        chk("arst_busy",  busy_o, 1'b0);
        chk("arst_done",  done_o, 1'b0);
        chk("arst_err",   error_o, 1'b0);
        chk("arst_nonce", nonce_o, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_null", pkt, NULLP);
            chk("post_rst_busy", busy_o, 1'b0);
        end
        do_load(32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
